// File: rtl/spi_burst_reader.sv
// spi_burst_reader: frames register reads/writes as chip-selected spi_master byte bursts.
// Ports: CLK/RESET_N (sync, active low); REQ* request in, REQ_ACK/BUSY status;
// CS_N/SPI_START/SPI_DATA to spi_master, SPI_BUSY/SPI_NEW_DATA/SPI_RX back;
// RD_DATA/RD_VALID read stream; DONE/ERR completion pulses.
module spi_burst_reader #(
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ,
  input  logic             REQ_WR,
  input  logic [6:0]       REQ_ADDR,
  input  logic [LEN_W-1:0] REQ_LEN,
  input  logic [7:0]       REQ_WDATA,
  output logic             REQ_ACK,
  output logic             BUSY,
  output logic             CS_N,
  output logic             SPI_START,
  output logic [7:0]       SPI_DATA,
  input  logic             SPI_BUSY,
  input  logic             SPI_NEW_DATA,
  input  logic [7:0]       SPI_RX,
  output logic [7:0]       RD_DATA,
  output logic             RD_VALID,
  output logic             DONE,
  output logic             ERR
);

  localparam int C1    = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CMAX  = (TIMEOUT > C1) ? TIMEOUT : C1;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   left_q, left_d;
  logic               wr_q, wr_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               first_q, first_d;
  logic               abort_q, abort_d;
  logic               cool_q, cool_d;

  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               cs_n_q, cs_n_d;
  logic               start_q, start_d;
  logic [7:0]         sdata_q, sdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    first_d  = first_q;
    abort_d  = abort_q;
    cool_d   = 1'b0;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    cs_n_d   = cs_n_q;
    start_d  = 1'b0;
    sdata_d  = sdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // cool_q blocks a REQ seen in the same cycle as DONE
        if (REQ && !cool_q) begin
          wr_d    = REQ_WR;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          if (REQ_WR)
            left_d = LEN_W'(1);
          else if (REQ_LEN > LEN_W'(MAX_LEN))
            left_d = LEN_W'(MAX_LEN);
          else
            left_d = REQ_LEN;
          first_d = 1'b1;
          abort_d = 1'b0;
          cnt_d   = '0;
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (!SPI_BUSY) begin
          if (first_q)
            sdata_d = {~wr_q, addr_q};
          else if (wr_q)
            sdata_d = wdata_q;
          else
            sdata_d = 8'h00;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (SPI_NEW_DATA) begin
          first_d = 1'b0;
          cnt_d   = '0;
          if (first_q) begin
            state_d = (left_q == '0) ? S_HOLD : S_ISSUE;
          end else begin
            if (!wr_q) begin
              rdata_d  = SPI_RX;
              rvalid_d = 1'b1;
            end
            left_d  = left_q - 1'b1;
            state_d = (left_q == LEN_W'(1)) ? S_HOLD : S_ISSUE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = !abort_q;
          cool_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      left_q   <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      first_q  <= 1'b0;
      abort_q  <= 1'b0;
      cool_q   <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      start_q  <= 1'b0;
      sdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      first_q  <= first_d;
      abort_q  <= abort_d;
      cool_q   <= cool_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      cs_n_q   <= cs_n_d;
      start_q  <= start_d;
      sdata_q  <= sdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign REQ_ACK   = ack_q;
  assign BUSY      = busy_q;
  assign CS_N      = cs_n_q;
  assign SPI_START = start_q;
  assign SPI_DATA  = sdata_q;
  assign RD_DATA   = rdata_q;
  assign RD_VALID  = rvalid_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_spi_burst_reader.sv
// tb_spi_burst_reader: directed bench for spi_burst_reader.
// Includes a small spi_master stand-in with programmable reply bytes.
module tb_spi_burst_reader;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       REQ = 1'b0;
  logic       REQ_WR = 1'b0;
  logic [6:0] REQ_ADDR = '0;
  logic [4:0] REQ_LEN = '0;
  logic [7:0] REQ_WDATA = '0;
  logic       REQ_ACK, BUSY, CS_N, SPI_START;
  logic [7:0] SPI_DATA, RD_DATA;
  logic       RD_VALID, DONE, ERR;
  logic       SPI_BUSY = 1'b0;
  logic       SPI_NEW_DATA = 1'b0;
  logic [7:0] SPI_RX = 8'h00;

  spi_burst_reader dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR),
    .REQ_LEN(REQ_LEN), .REQ_WDATA(REQ_WDATA),
    .REQ_ACK(REQ_ACK), .BUSY(BUSY), .CS_N(CS_N),
    .SPI_START(SPI_START), .SPI_DATA(SPI_DATA),
    .SPI_BUSY(SPI_BUSY), .SPI_NEW_DATA(SPI_NEW_DATA),
    .SPI_RX(SPI_RX), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  int cyc = 0, n_start = 0, n_done = 0, n_err = 0, n_ack = 0;
  int n_rise = 0, n_viol = 0, bcnt = 0;
  int t_start = 0, t_first = 0, t_err = 0, t_fall = 0, t_rise = 0, t_nd = 0;
  int mute_at = 1 << 30;
  int spur_req = 0, spur_done = 0;
  logic prev_cs = 1'b1;
  logic first_pend = 1'b0;
  logic [7:0] sent[$];
  logic [7:0] rd_log[$];
  logic [7:0] rx_q[$];

  int s_start, s_done, s_err, s_ack, s_rise;

  always @(negedge CLK) begin
    cyc++;
    if (SPI_START) begin
      n_start++;
      sent.push_back(SPI_DATA);
      t_start = cyc;
      if (SPI_BUSY) n_viol++;
      if (first_pend) begin
        t_first = cyc;
        first_pend = 1'b0;
      end
    end
    if (RD_VALID) rd_log.push_back(RD_DATA);
    if (DONE) n_done++;
    if (ERR) begin
      n_err++;
      t_err = cyc;
    end
    if (REQ_ACK) n_ack++;
    if (prev_cs && !CS_N) begin
      t_fall = cyc;
      first_pend = 1'b1;
    end
    if (!prev_cs && CS_N) begin
      t_rise = cyc;
      n_rise++;
    end
    prev_cs = CS_N;

    SPI_NEW_DATA = 1'b0;
    if (SPI_START) begin
      SPI_BUSY = 1'b1;
      bcnt = 2;
    end else if (SPI_BUSY) begin
      if (bcnt > 0) begin
        bcnt--;
      end else begin
        SPI_BUSY = 1'b0;
        if (n_start < mute_at) begin
          SPI_NEW_DATA = 1'b1;
          SPI_RX = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hDD;
          t_nd = cyc;
        end
      end
    end else if (spur_req != spur_done) begin
      spur_done++;
      SPI_NEW_DATA = 1'b1;
      SPI_RX = 8'hEE;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] q[$], input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++)
      r = (r << 8) | ((i < q.size()) ? {24'h0, q[i]} : 32'hFF);
    return r;
  endfunction

  function automatic logic [7:0] at(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 8'hFF;
  endfunction

  task automatic snap();
    s_start = n_start;
    s_done  = n_done;
    s_err   = n_err;
    s_ack   = n_ack;
    s_rise  = n_rise;
    sent.delete();
    rd_log.delete();
  endtask

  task automatic req_go(input logic wr, input logic [6:0] a,
                        input logic [4:0] l, input logic [7:0] wd,
                        input logic keep);
    @(negedge CLK);
    REQ = 1'b1;
    REQ_WR = wr;
    REQ_ADDR = a;
    REQ_LEN = l;
    REQ_WDATA = wd;
    @(negedge CLK);
    if (!keep) REQ = 1'b0;
  endtask

  task automatic finish_tx();
    int k = 0;
    while (BUSY && k < 5000) begin
      @(negedge CLK);
      k++;
    end
    REQ = 1'b0;
    chk("idle_wait", {31'h0, BUSY}, 0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_ctl", {25'h0, CS_N, BUSY, REQ_ACK, SPI_START, RD_VALID, DONE, ERR},
        32'b1000000);
    chk("rst_sdata", {24'h0, SPI_DATA}, 0);
    chk("rst_rdata", {24'h0, RD_DATA}, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // burst read of 3
    snap();
    rx_q = '{8'h11, 8'hA5, 8'h3C, 8'h7E};
    req_go(1'b0, 7'h0F, 5'd3, 8'h00, 1'b0);
    finish_tx();
    chk("rd3_starts", n_start - s_start, 4);
    chk("rd3_bytes", pk(sent, 4), 32'h8F000000);
    chk("rd3_nvalid", rd_log.size(), 3);
    chk("rd3_data", pk(rd_log, 3), 32'hA53C7E);
    chk("rd3_done", n_done - s_done, 1);
    chk("rd3_ack", n_ack - s_ack, 1);
    chk("rd3_cs_once", n_rise - s_rise, 1);
    chk("rd3_setup", {31'h0, (t_first - t_fall) >= 4}, 1);
    chk("rd3_hold", {31'h0, (t_rise - t_nd) >= 4}, 1);

    // single write
    snap();
    rx_q = '{8'h11, 8'h22};
    req_go(1'b1, 7'h20, 5'd0, 8'h55, 1'b0);
    finish_tx();
    chk("wr_starts", n_start - s_start, 2);
    chk("wr_bytes", pk(sent, 2), 32'h2055);
    chk("wr_nvalid", rd_log.size(), 0);
    chk("wr_done", n_done - s_done, 1);

    // address-only read
    snap();
    rx_q = '{8'h11};
    req_go(1'b0, 7'h33, 5'd0, 8'h00, 1'b0);
    finish_tx();
    chk("len0_starts", n_start - s_start, 1);
    chk("len0_byte", {24'h0, at(sent, 0)}, 32'hB3);
    chk("len0_nvalid", rd_log.size(), 0);
    chk("len0_done", n_done - s_done, 1);

    // clamped burst
    snap();
    rx_q.delete();
    rx_q.push_back(8'h00);
    for (int i = 0; i < 17; i++) rx_q.push_back(8'h40 + 8'(i));
    req_go(1'b0, 7'h01, 5'd31, 8'h00, 1'b0);
    finish_tx();
    chk("clamp_starts", n_start - s_start, 17);
    chk("clamp_nvalid", rd_log.size(), 16);
    chk("clamp_first", pk(rd_log, 4), 32'h40414243);
    chk("clamp_last", {24'h0, at(rd_log, 15)}, 32'h4F);
    chk("clamp_done", n_done - s_done, 1);
    rx_q.delete();

    // timeout on the second byte
    snap();
    mute_at = n_start + 2;
    rx_q = '{8'h11, 8'h01, 8'h02};
    req_go(1'b0, 7'h05, 5'd2, 8'h00, 1'b0);
    finish_tx();
    chk("to_err", n_err - s_err, 1);
    chk("to_nodone", n_done - s_done, 0);
    chk("to_latency", t_err - t_start, 1024);
    chk("to_hold", t_rise - t_err, 4);
    mute_at = 1 << 30;
    rx_q.delete();
    snap();
    rx_q = '{8'h11, 8'h22};
    req_go(1'b1, 7'h21, 5'd0, 8'h66, 1'b0);
    finish_tx();
    chk("to_next_ack", n_ack - s_ack, 1);
    chk("to_next_done", n_done - s_done, 1);
    chk("to_next_bytes", pk(sent, 2), 32'h2166);

    // REQ held high plus stray new_data in SETUP
    snap();
    rx_q = '{8'h11, 8'h9A};
    req_go(1'b0, 7'h02, 5'd1, 8'h00, 1'b1);
    spur_req++;
    finish_tx();
    chk("hold_ack", n_ack - s_ack, 1);
    chk("hold_nvalid", rd_log.size(), 1);
    chk("hold_data", {24'h0, at(rd_log, 0)}, 32'h9A);
    chk("hold_done", n_done - s_done, 1);
    chk("hold_spur", spur_done, 1);

    // reset during the second data byte
    snap();
    rx_q = '{8'h11, 8'hC1, 8'hC2, 8'hC3};
    req_go(1'b0, 7'h0A, 5'd3, 8'h00, 1'b0);
    begin
      int k = 0;
      while ((n_start - s_start) < 3 && k < 2000) begin
        @(negedge CLK);
        k++;
      end
    end
    chk("rst_reach", n_start - s_start, 3);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    chk("rst_mid_ctl", {30'h0, CS_N, BUSY}, 32'b10);
    repeat (20) @(negedge CLK);
    chk("rst_mid_nodone", n_done - s_done, 0);
    chk("rst_mid_noerr", n_err - s_err, 0);
    rx_q.delete();
    snap();
    rx_q = '{8'h11, 8'hB1, 8'hB2};
    req_go(1'b0, 7'h0F, 5'd2, 8'h00, 1'b0);
    finish_tx();
    chk("post_rst_bytes", pk(sent, 3), 32'h8F0000);
    chk("post_rst_data", pk(rd_log, 2), 32'hB1B2);
    chk("post_rst_done", n_done - s_done, 1);

    chk("start_vs_busy", n_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
